// File: rtl/serdesphy_tx_sched_if.sv
// Handshake and control bundle between the TX scheduler and the TX data mux.
// The scheduler drives enable/idle/select; the mux side reports valid/ready toward the encoder.
interface serdesphy_tx_sched_if;
    logic mux_enable;
    logic mux_tx_idle;
    logic mux_tx_data_sel;
    logic mux_valid;
    logic mux_ready;

    modport master (
        output mux_enable,
        output mux_tx_idle,
        output mux_tx_data_sel,
        input  mux_valid,
        input  mux_ready
    );

    modport slave (
        input  mux_enable,
        input  mux_tx_idle,
        input  mux_tx_data_sel,
        output mux_valid,
        output mux_ready
    );
endinterface

// File: rtl/serdesphy_tx_sched.sv
// TX path sequencer: idle preamble, byte-aligned source switching with guard bytes, flushing shutdown.
// Optional FIFO underrun idle fill and counter: define SERDESPHY_TX_SCHED_UNDERRUN_FILL_EN.
module serdesphy_tx_sched #(
    parameter int unsigned PREAMBLE_BYTES = 4,
    parameter int unsigned GUARD_BYTES    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tx_en,
    input  logic                        tx_idle_req,
    input  logic                        tx_data_sel_req,
    input  logic                        fifo_empty,
    serdesphy_tx_sched_if.master        mux,
    output logic                        tx_active,
    output logic [2:0]                  sched_state,
    output logic                        switch_done,
    output logic [7:0]                  underrun_cnt
);

    localparam int unsigned MAX_BYTES = (PREAMBLE_BYTES > GUARD_BYTES) ? PREAMBLE_BYTES : GUARD_BYTES;
    localparam int unsigned CNT_W     = (MAX_BYTES > 0) ? $clog2(MAX_BYTES + 1) : 1;
    localparam int unsigned FLUSH_W   = 4;
    localparam logic [CNT_W-1:0]   PRE_LAST   = CNT_W'((PREAMBLE_BYTES > 0) ? PREAMBLE_BYTES - 1 : 0);
    localparam logic [CNT_W-1:0]   GUARD_LAST = CNT_W'((GUARD_BYTES > 0) ? GUARD_BYTES - 1 : 0);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(15);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_WARMUP = 3'd1,
        ST_RUN    = 3'd2,
        ST_GUARD  = 3'd3,
        ST_FLUSH  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FLUSH_W-1:0] flush_q, flush_d;
    logic               src_q, src_d;
    logic               fill_q, fill_d;
    logic [7:0]         und_d;
    logic               sw_d;
    logic               en_d, idle_d, act_d;
    logic               beat;

    assign beat = mux.mux_valid && mux.mux_ready;

`ifndef SERDESPHY_TX_SCHED_UNDERRUN_FILL_EN
    logic unused_fifo_empty;
    assign unused_fifo_empty = fifo_empty;
`endif

    // Next-state, latch and output-next computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flush_d = flush_q;
        src_d   = src_q;
        fill_d  = fill_q;
        und_d   = underrun_cnt;
        sw_d    = 1'b0;

        case (state_q)
            ST_OFF: begin
                if (tx_en) begin
                    src_d   = tx_data_sel_req;
                    cnt_d   = '0;
                    state_d = (PREAMBLE_BYTES == 0) ? ST_RUN : ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                if (beat) begin
                    if (cnt_q == PRE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RUN: begin
`ifdef SERDESPHY_TX_SCHED_UNDERRUN_FILL_EN
                if (beat && !src_q) begin
                    fill_d = fifo_empty;
                    if (fifo_empty && underrun_cnt != 8'hFF) begin
                        und_d = underrun_cnt + 8'd1;
                    end
                end
`endif
                if (beat && (tx_data_sel_req != src_q)) begin
                    if (GUARD_BYTES == 0) begin
                        src_d = tx_data_sel_req;
                        sw_d  = 1'b1;
                    end else begin
                        state_d = ST_GUARD;
                        cnt_d   = '0;
                    end
                end
            end
            ST_GUARD: begin
                // Request is resampled at exit, so a toggle-back leaves the latch untouched
                if (beat) begin
                    if (cnt_q == GUARD_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        src_d   = tx_data_sel_req;
                        sw_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (beat || flush_q == FLUSH_LAST) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else begin
                    flush_d = flush_q + FLUSH_W'(1);
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase

        // Dropping enable wins over any other transition
        if (state_q != ST_OFF && state_q != ST_FLUSH && !tx_en) begin
            state_d = ST_FLUSH;
            cnt_d   = '0;
            flush_d = '0;
            src_d   = src_q;
            sw_d    = 1'b0;
        end

        if (state_d != ST_RUN) begin
            fill_d = 1'b0;
        end

        en_d   = (state_d != ST_OFF);
        act_d  = (state_d == ST_RUN);
        idle_d = (state_d != ST_RUN) || tx_idle_req || (fill_d && !src_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= ST_OFF;
            cnt_q               <= '0;
            flush_q             <= '0;
            src_q               <= 1'b0;
            fill_q              <= 1'b0;
            underrun_cnt        <= 8'd0;
            switch_done         <= 1'b0;
            tx_active           <= 1'b0;
            sched_state         <= 3'd0;
            mux.mux_enable      <= 1'b0;
            mux.mux_tx_idle     <= 1'b1;
            mux.mux_tx_data_sel <= 1'b0;
        end else begin
            state_q             <= state_d;
            cnt_q               <= cnt_d;
            flush_q             <= flush_d;
            src_q               <= src_d;
            fill_q              <= fill_d;
            underrun_cnt        <= und_d;
            switch_done         <= sw_d;
            tx_active           <= act_d;
            sched_state         <= 3'(state_d);
            mux.mux_enable      <= en_d;
            mux.mux_tx_idle     <= idle_d;
            mux.mux_tx_data_sel <= src_d;
        end
    end

endmodule
